// File: rtl/sdram_write_sequencer.sv
// Buffers 16-bit words in a FIFO and issues one SDRAM write command per word, walking a linear
// bank/row/column address and pacing itself on the interface busy flag.
module sdram_write_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned WRAP        = 0,
  // Address loaded by RESET; {bank, row, col}. Nonzero only for bring-up of end-of-memory paths.
  parameter logic [23:0] INIT_ADDR   = 24'd0
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic [15:0] DATA_IN,
  input  logic        DATA_VALID,
  input  logic        SDRAM_STATUS,
  output logic [1:0]  CMD_OUT,
  output logic [1:0]  A_OUT_BANK,
  output logic [12:0] A_OUT_ROW,
  output logic [8:0]  A_OUT_COL,
  output logic [15:0] D_OUT,
  output logic        FIFO_FULL,
  output logic        OVERFLOW,
  output logic        MEM_FULL,
  output logic        ACK_ERR,
  output logic [23:0] WORD_COUNT
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TmoLast = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;

  localparam logic [1:0] CmdIdle  = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd2;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [23:0]   wcount_q, wcount_d;
  logic [15:0]   dout_q, dout_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, ovf_d;
  logic          mem_full_q, mem_full_d;
  logic          ack_err_q, ack_err_d;
  logic          push, pop;

  assign pop  = (state_q == StWaitDone) && !SDRAM_STATUS;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = DATA_VALID && ((count_q != DepthC) || pop);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wcount_d   = wcount_q;
    dout_d     = dout_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    mem_full_d = mem_full_q;
    ack_err_d  = ack_err_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (DATA_VALID && !push) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if ((count_q != '0) && !SDRAM_STATUS && !mem_full_q) begin
          state_d = StIssue;
          cmd_d   = CmdWrite;
          dout_d  = mem_q[rd_ptr_q];
          tmo_d   = '0;
        end
      end
      StIssue: begin
        if (SDRAM_STATUS) begin
          state_d = StWaitDone;
          cmd_d   = CmdIdle;
        end else if (tmo_q == TmoLast) begin
          // No acknowledge: drop back and retry the same word at the same address.
          state_d   = StIdle;
          cmd_d     = CmdIdle;
          ack_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!SDRAM_STATUS) begin
          state_d = StIdle;
          if (wcount_q != '1) begin
            wcount_d = wcount_q + 1'b1;
          end
          if ((addr_q == '1) && (WRAP == 0)) begin
            mem_full_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cmd_d   = CmdIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      cmd_q      <= CmdIdle;
      addr_q     <= INIT_ADDR;
      wcount_q   <= '0;
      dout_q     <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      mem_full_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wcount_q   <= wcount_d;
      dout_q     <= dout_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      mem_full_q <= mem_full_d;
      ack_err_q  <= ack_err_d;
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

  assign CMD_OUT    = cmd_q;
  assign A_OUT_BANK = addr_q[23:22];
  assign A_OUT_ROW  = addr_q[21:9];
  assign A_OUT_COL  = addr_q[8:0];
  assign D_OUT      = dout_q;
  assign FIFO_FULL  = (count_q == DepthC);
  assign OVERFLOW   = ovf_q;
  assign MEM_FULL   = mem_full_q;
  assign ACK_ERR    = ack_err_q;
  assign WORD_COUNT = wcount_q;

endmodule

// File: tb/tb_sdram_write_sequencer.sv
// Scoreboard bench: four sequencers (default, bank-rollover start, end-of-memory with and
// without wrap); expected writes are queued at push time and matched when CMD_OUT=2 appears.
module tb_sdram_write_sequencer;

  // {bank,row,col} start addresses: 0, (0,8191,511), (3,8191,511), (3,8191,511)
  localparam logic [95:0] INITS = {24'hFFFFFF, 24'hFFFFFF, 24'h3FFFFF, 24'h000000};

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst  [4];
  logic [15:0] din  [4];
  logic        vld  [4];
  logic        st   [4];
  logic [1:0]  cmd  [4];
  logic [1:0]  bank [4];
  logic [12:0] row  [4];
  logic [8:0]  col  [4];
  logic [15:0] dout [4];
  logic        full [4];
  logic        ovf  [4];
  logic        mfull[4];
  logic        aerr [4];
  logic [23:0] wc   [4];

  wr_t         exp_q[$];
  logic [23:0] maddr [4];
  int          cnt   [4];
  int          exp_wc[4];
  int          checks;
  int          failures;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sdram_write_sequencer #(
      .FIFO_DEPTH (8),
      .ACK_TIMEOUT(16),
      .WRAP       ((g == 3) ? 1 : 0),
      .INIT_ADDR  (INITS[g*24 +: 24])
    ) u_dut (
      .CLK_48MHZ   (clk),
      .RESET       (rst[g]),
      .DATA_IN     (din[g]),
      .DATA_VALID  (vld[g]),
      .SDRAM_STATUS(st[g]),
      .CMD_OUT     (cmd[g]),
      .A_OUT_BANK  (bank[g]),
      .A_OUT_ROW   (row[g]),
      .A_OUT_COL   (col[g]),
      .D_OUT       (dout[g]),
      .FIFO_FULL   (full[g]),
      .OVERFLOW    (ovf[g]),
      .MEM_FULL    (mfull[g]),
      .ACK_ERR     (aerr[g]),
      .WORD_COUNT  (wc[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [23:0] cur_addr(input int i);
    return {bank[i], row[i], col[i]};
  endfunction

  task automatic push(input int i, input logic [15:0] w);
    din[i] = w;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
    if (cnt[i] < 8) begin
      exp_q.push_back('{addr: maddr[i], data: w});
      maddr[i] = maddr[i] + 24'd1;
      cnt[i]++;
    end
  endtask

  task automatic wait_cmd(input int i, input string tag);
    int n;
    n = 0;
    while (cmd[i] != 2'd2 && n < 64) begin
      tick();
      n++;
    end
    if (cmd[i] != 2'd2) check_eq(tag, {30'd0, cmd[i]}, 32'd2);
  endtask

  // Acts as the SDRAM interface for one write: ack, stay busy, then release.
  task automatic serve(input int i, input int busy);
    wr_t e;
    st[i] = 1'b0;
    wait_cmd(i, "issue_wait");
    if (cmd[i] != 2'd2) return;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("wr_addr", {8'd0, cur_addr(i)}, {8'd0, e.addr});
    check_eq("wr_data", {16'd0, dout[i]}, {16'd0, e.data});
    st[i] = 1'b1;
    tick();
    check_eq("cmd_drop", {30'd0, cmd[i]}, 32'd0);
    repeat (busy - 1) tick();
    check_eq("hold_addr", {8'd0, cur_addr(i)}, {8'd0, e.addr});
    check_eq("hold_data", {16'd0, dout[i]}, {16'd0, e.data});
    st[i] = 1'b0;
    tick();
    cnt[i]--;
    exp_wc[i]++;
    check_eq("word_count", {8'd0, wc[i]}, exp_wc[i]);
  endtask

  task automatic expect_quiet(input int i, input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      if (cmd[i] == 2'd2) seen++;
      tick();
    end
    check_eq(tag, seen, 32'd0);
  endtask

  task automatic check_reset_outs(input int i, input string tag);
    check_eq(tag, {cmd[i], cur_addr(i), full[i], ovf[i], mfull[i], aerr[i]}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, dout[i]}, 32'd0);
    check_eq({tag, "_wc"}, {8'd0, wc[i]}, 32'd0);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin
      rst[i]    = 1'b1;
      din[i]    = '0;
      vld[i]    = 1'b0;
      st[i]     = 1'b0;
      maddr[i]  = INITS[i*24 +: 24];
      cnt[i]    = 0;
      exp_wc[i] = 0;
    end
    tick();
    tick();
    check_reset_outs(0, "reset");
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    tick();

    // Single write with two-edge latency.
    push(0, 16'hBEEF);
    check_eq("lat_edge1", {30'd0, cmd[0]}, 32'd0);
    tick();
    check_eq("lat_edge2", {30'd0, cmd[0]}, 32'd2);
    serve(0, 12);
    check_eq("single_next_col", {8'd0, cur_addr(0)}, 32'd1);

    // Overflow while the interface is busy.
    st[0] = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      push(0, 16'hA000 + 16'(k));
      if (k == 6) check_eq("full_at7", {31'd0, full[0]}, 32'd0);
      if (k == 7) check_eq("full_at8", {31'd0, full[0]}, 32'd1);
      if (k == 7) check_eq("ovf_at8", {31'd0, ovf[0]}, 32'd0);
      if (k == 8) check_eq("ovf_at9", {31'd0, ovf[0]}, 32'd1);
    end
    check_eq("no_issue_busy", {30'd0, cmd[0]}, 32'd0);
    for (int k = 0; k < 8; k++) serve(0, 3);
    check_eq("ovf_drained", exp_q.size(), 32'd0);
    expect_quiet(0, 6, "ovf_quiet");
    check_eq("ovf_not_full", {31'd0, full[0]}, 32'd0);

    // Timeout and retry of the same word.
    push(0, 16'hC0DE);
    wait_cmd(0, "tmo_issue");
    n = 0;
    while (cmd[0] == 2'd2 && n < 40) begin
      n++;
      tick();
    end
    check_eq("tmo_len", n, 32'd16);
    check_eq("ack_err", {31'd0, aerr[0]}, 32'd1);
    wait_cmd(0, "retry_issue");
    if (exp_q.size() != 0) begin
      check_eq("retry_addr", {8'd0, cur_addr(0)}, {8'd0, exp_q[0].addr});
      check_eq("retry_data", {16'd0, dout[0]}, {16'd0, exp_q[0].data});
    end
    serve(0, 4);
    expect_quiet(0, 6, "tmo_quiet");

    // Reset while the interface is mid-write.
    push(0, 16'h1234);
    wait_cmd(0, "rst_issue");
    st[0] = 1'b1;
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    check_reset_outs(0, "mid_reset");
    rst[0] = 1'b0;
    exp_q.delete();
    maddr[0]  = '0;
    cnt[0]    = 0;
    exp_wc[0] = 0;
    push(0, 16'h5A5A);
    tick();
    check_eq("rst_busy_hold", {30'd0, cmd[0]}, 32'd0);
    serve(0, 3);
    expect_quiet(0, 6, "rst_quiet");

    // Row and bank rollover from (0, 8191, 511).
    push(1, 16'h1111);
    push(1, 16'h2222);
    serve(1, 2);
    serve(1, 2);
    check_eq("roll_addr", {8'd0, cur_addr(1)}, {8'd0, 2'd1, 13'd0, 9'd1});

    // Last address without wrap.
    push(2, 16'h3333);
    push(2, 16'h4444);
    serve(2, 2);
    check_eq("mem_full", {31'd0, mfull[2]}, 32'd1);
    expect_quiet(2, 30, "mem_full_quiet");
    exp_q.delete();

    // Last address with wrap.
    push(3, 16'h5555);
    push(3, 16'h6666);
    serve(3, 2);
    serve(3, 2);
    check_eq("wrap_no_full", {31'd0, mfull[3]}, 32'd0);
    check_eq("wrap_addr", {8'd0, cur_addr(3)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_write_sequencer.md
# sdram_write_sequencer

Upstream command stage for `sdram_interface`: buffers 16-bit telemetry words in a small FIFO and turns each word into one SDRAM write command with a linearly advancing bank/row/column address. It drives the interface's `CMD_IN`, `A_IN_*` and `D_IN` inputs and paces itself on the interface's `STATUS` (busy) output. One word is written per interface write cycle, until the address space is exhausted or `WRAP` is set.

## Interface
- `FIFO_DEPTH`, 8: words of input buffering; power of 2, ≥2.
- `ACK_TIMEOUT`, 16: cycles to wait in ISSUE for `SDRAM_STATUS` to rise before flagging an error.
- `WRAP`, 0: 1 means the address wraps to 0 after the last location; 0 means stop and assert `MEM_FULL`.

Ports:
- `CLK_48MHZ` in 1: system clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `DATA_IN` in 16: word to store.
- `DATA_VALID` in 1: one-cycle push strobe for `DATA_IN`.
- `SDRAM_STATUS` in 1: busy from `sdram_interface`, 1 = busy.
- `CMD_OUT` out 2: to `CMD_IN`; 0 = idle, 2 = write. 1 = read is never driven.
- `A_OUT_BANK` out 2, `A_OUT_ROW` out 13, `A_OUT_COL` out 9: to `A_IN_BANK/ROW/COL`.
- `D_OUT` out 16: to `D_IN`.
- `FIFO_FULL` out 1: FIFO count == `FIFO_DEPTH`.
- `OVERFLOW` out 1: sticky; a push was dropped.
- `MEM_FULL` out 1: sticky; last address has been written (`WRAP`=0 only).
- `ACK_ERR` out 1: sticky; `ACK_TIMEOUT` expired at least once.
- `WORD_COUNT` out 24: count of completed writes; saturates at 2^24−1.

## Operation
- **Reset values**: all outputs 0, FIFO empty, state IDLE.
- **FIFO push**: `DATA_VALID`=1 with count<`FIFO_DEPTH`, or with a pop in the same cycle, stores the word.
  - Otherwise the word is dropped and `OVERFLOW` is set.
- **FIFO pop**: occurs only on the WAIT_DONE→IDLE transition.
- **Address order**: column increments 0→511; at 511 the column returns to 0 and the row increments; at row 8191 the row returns to 0 and the bank increments.
  - After bank 3 / row 8191 / col 511 is written: with `WRAP`=0, set `MEM_FULL` and stay in IDLE permanently (FIFO still accepts, then overflows). With `WRAP`=1, return to address 0.
- **IDLE**: the transition to ISSUE requires FIFO not empty, `SDRAM_STATUS`=0 and `MEM_FULL`=0.
  - On entry to ISSUE: `D_OUT`←FIFO head, `CMD_OUT`←2, timeout counter←0.
- **ISSUE**: hold `CMD_OUT`=2, address and `D_OUT`.
  - `SDRAM_STATUS`=1 → WAIT_DONE with `CMD_OUT`←0.
  - Timeout counter reaching `ACK_TIMEOUT` → set `ACK_ERR`, `CMD_OUT`←0, return to IDLE without a pop (retry).
- **WAIT_DONE**: `CMD_OUT`=0; address and `D_OUT` held stable, because the interface latches the column and data late in its cycle.
  - `SDRAM_STATUS`=0 → IDLE, pop the FIFO, advance the address, increment `WORD_COUNT`.
- **Power-up**: `STATUS` stays high during the interface's power-up sequence, so nothing is issued until it first reads 0.
- **`RESET` mid-operation**: everything returns to reset values on that edge. An interface cycle already in progress completes on its own. The FIFO contents are lost, and the address restarts at bank 0 / row 0 / col 0.

## Timing
- All outputs are registered on the rising edge and are stable at the falling edge, where `sdram_interface` samples them.
- Push at edge N: the word is visible to IDLE at edge N+1. Latency from push into an empty FIFO with `STATUS`=0 to `CMD_OUT`=2 is 2 edges.
- `CMD_OUT`=2 is held for at least 1 cycle and at most `ACK_TIMEOUT` cycles.
- `CMD_OUT` returns to 0 on the edge after `STATUS` is seen high, so a second write is never requested on the interface's exit edge.
- Back-to-back words: the next ISSUE begins the cycle after the WAIT_DONE→IDLE transition, with the new address already on the bus.
- Simultaneous push and pop when full: the push is accepted, the count is unchanged, and `OVERFLOW` is not set.

## Test plan
- **Single write**: reset, hold `STATUS`=0, push 0xBEEF.
  - `CMD_OUT`=2 with addr 0/0/0 and `D_OUT`=0xBEEF.
  - Model `STATUS` high for 12 cycles then low: `CMD_OUT`=0 after the rise, address becomes col 1, `WORD_COUNT`=1.
- **Overflow**: `STATUS` held 1, push 10 words.
  - `FIFO_FULL`=1 after the 8th, `OVERFLOW`=1 after the 9th.
  - Releasing `STATUS` writes exactly the first 8 words, in order.
- **Column/row/bank rollover**: preload the address to col 511 / row 8191 / bank 0 via writes and push 2 words. The addresses issued are (0, 8191, 511) and then (1, 0, 0).
- **End of memory**: at (3, 8191, 511) write 1 word.
  - With `WRAP`=0: `MEM_FULL`=1 and no further `CMD_OUT`=2.
  - With `WRAP`=1: the next write goes to (0, 0, 0).
- **Timeout**: push 1 word, keep `STATUS`=0 forever.
  - `ACK_ERR`=1 after 16 cycles; the same word and address are retried, and the FIFO count stays 1.
- **Reset mid-write**: assert `RESET` during WAIT_DONE. On the next edge all outputs are 0 and the FIFO is empty; after `STATUS` falls, a new push is written to (0, 0, 0).
